int_isq_nwb: RTL and testbench
==============================

INT_ISQ_NWB -- requirements
Module: int_isq_nwb

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count (power of 2, at least 2).
REQ-002 SHALL have parameter NUM_WB, default 2, writeback/wakeup port count (at least 1).
REQ-003 SHALL have parameter PREG_WIDTH, default 6, physical register index width.
REQ-004 SHALL have parameter ROBID_WIDTH, default 7, ROB id width; the MSB is the wrap bit.
REQ-005 SHALL have parameter PAYLOAD_WIDTH, default 128, opaque micro-op payload width.
REQ-006 SHALL have ports: one clock; reset is asynchronous and active-low.
- clock  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- enq_valid  in  1  enqueue request
- enq_ready  out  1  entry available
- enq_payload  in  PAYLOAD_WIDTH  micro-op payload
- enq_robid  in  ROBID_WIDTH  ROB id
- enq_prs1 / enq_prs2  in  PREG_WIDTH each  source pregs
- enq_src1_rdy / enq_src2_rdy  in  1 each  source already ready at rename
- deq_valid  out  1  ready entry selected
- deq_ready  in  1  execution unit accepts
- deq_payload  out  PAYLOAD_WIDTH  selected payload
- deq_robid  out  ROBID_WIDTH  selected ROB id
- wb_valid  in  NUM_WB  writeback valid per port
- wb_prd  in  NUM_WB*PREG_WIDTH  writeback preg, port k at bits [k*PREG_WIDTH +: PREG_WIDTH]
- flush_valid  in  1  redirect flush
- flush_robid  in  ROBID_WIDTH  flush boundary
- count  out  $clog2(DEPTH)+1  valid entry count
- intisq_can_enq  out  1  equals enq_ready

Function
REQ-007 SHALL store per entry: valid, payload, robid, prs1, prs2, src1_rdy, src2_rdy.
REQ-008 SHALL drive enq_ready = (count < DEPTH) and !flush_valid; an enqueue fires when enq_valid and enq_ready.
REQ-009 SHALL write a fired enqueue into the lowest-index free entry at the next rising edge.
REQ-010 SHALL use a DEPTH x DEPTH age matrix; on enqueue, the new entry is marked younger than every currently valid entry.
REQ-011 SHALL drive deq_valid combinationally when any valid entry has both sources ready and flush_valid is 0.
REQ-012 SHALL select the oldest such entry per the age matrix; ROB id is not used for selection.
REQ-013 SHALL invalidate the selected entry at the edge where deq_valid and deq_ready; deq_payload/deq_robid SHALL be stable while deq_valid and not deq_ready, unless an older entry becomes ready.
REQ-014 SHALL set src1_rdy (src2_rdy) on every valid entry whose prs1 (prs2) equals wb_prd[k] with wb_valid[k], for any k, at the next edge; all matching entries wake, not only one.
REQ-015 SHALL NOT allow an entry woken in cycle N to issue before cycle N+1.
REQ-016 SHALL, on flush_valid, invalidate at the next edge every entry whose robid is strictly younger than flush_robid: (wrap bits differ) XOR (low bits entry > low bits flush).
REQ-017 SHALL suppress enqueue and dequeue in the flush cycle.
REQ-018 SHALL permit enqueue and dequeue in the same cycle; count is unchanged and a slot freed by dequeue is not reusable until the next cycle.
REQ-019 SHALL keep count equal to the number of valid entries after every edge, including when flush and wakeup occur in the same cycle.

Reset
REQ-020 SHALL, while reset_n is low, clear all valid bits, ready bits and the age matrix, and force count=0, enq_ready=0 and deq_valid=0.
REQ-021 SHALL raise enq_ready in the first cycle after reset_n deasserts; payload storage needs no reset.

Configuration
REQ-022 SHALL, with INT_ISQ_ENQ_BYPASS_EN defined, set an enqueued source ready if it matches any same-cycle valid wb_prd, in addition to enq_srcX_rdy.
REQ-023 SHALL, without INT_ISQ_ENQ_BYPASS_EN, use only enq_src1_rdy/enq_src2_rdy at enqueue; the same-cycle wakeup is lost and the rename stage must cover it.

Verification
REQ-024 Bench SHALL cover: enqueue A(robid 3) then B(robid 4), both ready, deq_ready=1 -> A issues, then B.
REQ-025 Bench SHALL cover: 8 enqueues with sources not ready -> count=8, enq_ready=0; wb_valid[1]=1 with a prd shared by 3 entries -> all 3 wake and issue oldest-first on consecutive cycles.
REQ-026 Bench SHALL cover: entries with robids 0x7E, 0x7F, 0x00 (wrapped) and flush_robid=0x7F -> only the 0x00 entry is removed; count drops 3->2.
REQ-027 Bench SHALL cover: full queue with dequeue and enqueue in the same cycle -> enqueue blocked, count 8->7, enqueue accepted next cycle.
REQ-028 Bench SHALL cover: enqueue prs1=5 (not ready) while wb_prd[0]=5 -> issuable next cycle with INT_ISQ_ENQ_BYPASS_EN defined, never issues without it.
REQ-029 Bench SHALL cover: reset_n asserted with 4 valid entries -> deq_valid=0 and count=0 immediately.

Source files
------------

// File: rtl/int_isq_nwb.sv
// int_isq_nwb: integer issue queue with an age matrix, oldest-ready select,
// NUM_WB-port wakeup and ROB-id based flush.
// Optional feature: define INT_ISQ_ENQ_BYPASS_EN so that an enqueuing
// micro-op also catches a writeback that arrives in its own enqueue cycle.
module int_isq_nwb #(
    parameter int DEPTH         = 8,
    parameter int NUM_WB        = 2,
    parameter int PREG_WIDTH    = 6,
    parameter int ROBID_WIDTH   = 7,
    parameter int PAYLOAD_WIDTH = 128
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [PAYLOAD_WIDTH-1:0]     enq_payload,
    input  logic [ROBID_WIDTH-1:0]       enq_robid,
    input  logic [PREG_WIDTH-1:0]        enq_prs1,
    input  logic [PREG_WIDTH-1:0]        enq_prs2,
    input  logic                         enq_src1_rdy,
    input  logic                         enq_src2_rdy,
    output logic                         deq_valid,
    input  logic                         deq_ready,
    output logic [PAYLOAD_WIDTH-1:0]     deq_payload,
    output logic [ROBID_WIDTH-1:0]       deq_robid,
    input  logic [NUM_WB-1:0]            wb_valid,
    input  logic [NUM_WB*PREG_WIDTH-1:0] wb_prd,
    input  logic                         flush_valid,
    input  logic [ROBID_WIDTH-1:0]       flush_robid,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         intisq_can_enq
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int LOW_W = ROBID_WIDTH - 1;

    // An entry is younger than the flush boundary when the wrap bits differ
    // XOR its low bits are larger.
    function automatic logic is_younger(input logic [ROBID_WIDTH-1:0] e,
                                        input logic [ROBID_WIDTH-1:0] f);
        logic wrap_diff;
        logic low_gt;
        wrap_diff = e[ROBID_WIDTH-1] ^ f[ROBID_WIDTH-1];
        low_gt    = (e[LOW_W-1:0] > f[LOW_W-1:0]);
        return wrap_diff ^ low_gt;
    endfunction

    // True when any valid writeback port carries preg p.
    function automatic logic wb_hit(input logic [PREG_WIDTH-1:0]        p,
                                    input logic [NUM_WB-1:0]            v,
                                    input logic [NUM_WB*PREG_WIDTH-1:0] prd);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (v[k] && (prd[k*PREG_WIDTH +: PREG_WIDTH] == p)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Control state (reset)
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] src1_rdy_q, src1_rdy_d;
    logic [DEPTH-1:0] src2_rdy_q, src2_rdy_d;
    // older_q[i][j] set means entry i is older than entry j
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;

    // Entry storage (no reset, only meaningful while the valid bit is set)
    logic [PAYLOAD_WIDTH-1:0] payload_q [DEPTH];
    logic [ROBID_WIDTH-1:0]   robid_q   [DEPTH];
    logic [PREG_WIDTH-1:0]    prs1_q    [DEPTH];
    logic [PREG_WIDTH-1:0]    prs2_q    [DEPTH];

    logic [IDX_W-1:0] free_idx;
    logic [DEPTH-1:0] issuable;
    logic [DEPTH-1:0] grant;
    logic             enq_fire;
    logic             deq_fire;
    logic             enq_s1_rdy;
    logic             enq_s2_rdy;

    // Handshake outputs; both sides are blocked during a flush cycle.
    assign enq_ready      = reset_n && !flush_valid && (count_q < CNT_W'(DEPTH));
    assign intisq_can_enq = enq_ready;
    assign deq_valid      = reset_n && !flush_valid && (|issuable);
    assign count          = count_q;
    assign enq_fire       = enq_valid && enq_ready;
    assign deq_fire       = deq_valid && deq_ready;

`ifdef INT_ISQ_ENQ_BYPASS_EN
    assign enq_s1_rdy = enq_src1_rdy || wb_hit(enq_prs1, wb_valid, wb_prd);
    assign enq_s2_rdy = enq_src2_rdy || wb_hit(enq_prs2, wb_valid, wb_prd);
`else
    assign enq_s1_rdy = enq_src1_rdy;
    assign enq_s2_rdy = enq_src2_rdy;
`endif

    // Lowest-index free slot: scan downward so the last hit is the lowest.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // Oldest-ready select: an issuable entry wins unless an older issuable one exists.
    always_comb begin
        issuable = valid_q & src1_rdy_q & src2_rdy_q;
        grant    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = issuable[i];
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && issuable[j] && older_q[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

    // One-hot read mux for the selected entry.
    always_comb begin
        deq_payload = '0;
        deq_robid   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                deq_payload = deq_payload | payload_q[i];
                deq_robid   = deq_robid | robid_q[i];
            end
        end
    end

    // Next state: wakeup, flush, dequeue, enqueue, then recount.
    always_comb begin
        valid_d    = valid_q;
        src1_rdy_d = src1_rdy_q;
        src2_rdy_d = src2_rdy_q;
        older_d    = older_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && wb_hit(prs1_q[i], wb_valid, wb_prd)) begin
                src1_rdy_d[i] = 1'b1;
            end
            if (valid_q[i] && wb_hit(prs2_q[i], wb_valid, wb_prd)) begin
                src2_rdy_d[i] = 1'b1;
            end
            if (flush_valid && valid_q[i] && is_younger(robid_q[i], flush_robid)) begin
                valid_d[i] = 1'b0;
            end
        end

        // deq_fire and enq_fire are both zero in a flush cycle
        if (deq_fire) begin
            valid_d = valid_d & ~grant;
        end

        // The free slot is never the granted slot, so a freed slot waits a cycle.
        if (enq_fire) begin
            valid_d[free_idx]    = 1'b1;
            src1_rdy_d[free_idx] = enq_s1_rdy;
            src2_rdy_d[free_idx] = enq_s2_rdy;
            older_d[free_idx]    = '0;
            for (int i = 0; i < DEPTH; i++) begin
                older_d[i][free_idx] = valid_q[i];
            end
        end

        count_d = popcount(valid_d);
    end

    // Control registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= '0;
            src1_rdy_q <= '0;
            src2_rdy_q <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            src1_rdy_q <= src1_rdy_d;
            src2_rdy_q <= src2_rdy_d;
            count_q    <= count_d;
            older_q    <= older_d;
        end
    end

    // Entry storage written only on an accepted enqueue.
    always_ff @(posedge clock) begin
        if (enq_fire) begin
            payload_q[free_idx] <= enq_payload;
            robid_q[free_idx]   <= enq_robid;
            prs1_q[free_idx]    <= enq_prs1;
            prs2_q[free_idx]    <= enq_prs2;
        end
    end

endmodule

// File: tb/tb_int_isq_nwb.sv
// tb_int_isq_nwb: directed scenarios plus randomized traffic against an
// in-order queue model of the issue queue.
module tb_int_isq_nwb;

    localparam int DEPTH = 8;
    localparam int NUM_WB = 2;
    localparam int PW = 6;
    localparam int RW = 7;
    localparam int DW = 128;

`ifdef INT_ISQ_ENQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   enq_valid;
    logic                   enq_ready;
    logic [DW-1:0]          enq_payload;
    logic [RW-1:0]          enq_robid;
    logic [PW-1:0]          enq_prs1;
    logic [PW-1:0]          enq_prs2;
    logic                   enq_src1_rdy;
    logic                   enq_src2_rdy;
    logic                   deq_valid;
    logic                   deq_ready;
    logic [DW-1:0]          deq_payload;
    logic [RW-1:0]          deq_robid;
    logic [NUM_WB-1:0]      wb_valid;
    logic [NUM_WB*PW-1:0]   wb_prd;
    logic                   flush_valid;
    logic [RW-1:0]          flush_robid;
    logic [$clog2(DEPTH):0] count;
    logic                   intisq_can_enq;

    int n_checks = 0;
    int n_pass = 0;

    int_isq_nwb #(
        .DEPTH(DEPTH), .NUM_WB(NUM_WB), .PREG_WIDTH(PW),
        .ROBID_WIDTH(RW), .PAYLOAD_WIDTH(DW)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_payload(enq_payload),
        .enq_robid(enq_robid), .enq_prs1(enq_prs1), .enq_prs2(enq_prs2),
        .enq_src1_rdy(enq_src1_rdy), .enq_src2_rdy(enq_src2_rdy),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_payload(deq_payload),
        .deq_robid(deq_robid), .wb_valid(wb_valid), .wb_prd(wb_prd),
        .flush_valid(flush_valid), .flush_robid(flush_robid),
        .count(count), .intisq_can_enq(intisq_can_enq)
    );

    always #5 clock = ~clock;

    // Model: entries kept in a queue in program (enqueue) order, oldest first.
    typedef struct {
        logic [RW-1:0] robid;
        logic [DW-1:0] payload;
        logic [PW-1:0] prs1;
        logic [PW-1:0] prs2;
        bit            r1;
        bit            r2;
    } ent_t;

    ent_t mq[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit wb_match(input logic [PW-1:0] p);
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && (wb_prd[k*PW +: PW] == p)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int oldest_ready();
        foreach (mq[i]) begin
            if (mq[i].r1 && mq[i].r2) return i;
        end
        return -1;
    endfunction

    // Circular ROB-id distance: younger means 1..2^(RW-1) steps after the boundary.
    function automatic bit younger(input logic [RW-1:0] e, input logic [RW-1:0] f);
        int d;
        d = (int'(e) - int'(f) + (1 << RW)) % (1 << RW);
        return (d >= 1) && (d <= (1 << (RW - 1)));
    endfunction

    function automatic bit m_enq_ready();
        return reset_n && (mq.size() < DEPTH) && !flush_valid;
    endfunction

    function automatic bit m_deq_valid();
        return reset_n && !flush_valid && (oldest_ready() >= 0);
    endfunction

    // Model state update at each edge.
    always @(posedge clock or negedge reset_n) begin : upd
        bit   ef;
        bit   df;
        int   sel;
        ent_t ne;
        if (!reset_n) begin
            mq.delete();
        end else begin
            ef = m_enq_ready() && enq_valid;
            df = m_deq_valid() && deq_ready;
            sel = oldest_ready();
            ne.robid   = enq_robid;
            ne.payload = enq_payload;
            ne.prs1    = enq_prs1;
            ne.prs2    = enq_prs2;
            ne.r1      = enq_src1_rdy || (BYPASS && wb_match(enq_prs1));
            ne.r2      = enq_src2_rdy || (BYPASS && wb_match(enq_prs2));
            if (flush_valid) begin
                for (int i = mq.size() - 1; i >= 0; i--) begin
                    if (younger(mq[i].robid, flush_robid)) mq.delete(i);
                end
            end else if (df) begin
                mq.delete(sel);
            end
            foreach (mq[i]) begin
                if (wb_match(mq[i].prs1)) mq[i].r1 = 1'b1;
                if (wb_match(mq[i].prs2)) mq[i].r2 = 1'b1;
            end
            if (ef) mq.push_back(ne);
        end
    end

    // Compare DUT outputs with the model on every falling edge.
    always @(negedge clock) begin : cmp
        int sel;
        sel = oldest_ready();
        chk("enq_ready", enq_ready, m_enq_ready());
        chk("intisq_can_enq", intisq_can_enq, m_enq_ready());
        chk("deq_valid", deq_valid, m_deq_valid());
        chk("count", count, mq.size());
        if (m_deq_valid()) begin
            chk("deq_robid", deq_robid, mq[sel].robid);
            chk("deq_payload", deq_payload, mq[sel].payload);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        enq_valid = 1'b0; enq_payload = '0; enq_robid = '0;
        enq_prs1 = '0; enq_prs2 = '0; enq_src1_rdy = 1'b0; enq_src2_rdy = 1'b0;
        deq_ready = 1'b0; wb_valid = '0; wb_prd = '0;
        flush_valid = 1'b0; flush_robid = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        step();
        chk("rst_count", count, 0);
        chk("rst_enq_ready", enq_ready, 0);
        chk("rst_deq_valid", deq_valid, 0);
        step();
        reset_n = 1'b1;
        #1;
        chk("enq_ready_after_reset", enq_ready, 1);
    endtask

    task automatic enq(input logic [RW-1:0] rid, input logic [PW-1:0] p1,
                       input logic [PW-1:0] p2, input logic r1, input logic r2,
                       input logic [DW-1:0] pl);
        enq_valid = 1'b1; enq_robid = rid; enq_prs1 = p1; enq_prs2 = p2;
        enq_src1_rdy = r1; enq_src2_rdy = r2; enq_payload = pl;
        step();
        enq_valid = 1'b0;
    endtask

    initial begin
        idle_inputs();

        // A(robid 3) then B(robid 4), both ready: A issues first, then B.
        do_reset();
        enq(7'd3, 6'd1, 6'd2, 1'b1, 1'b1, 128'hA);
        enq(7'd4, 6'd1, 6'd2, 1'b1, 1'b1, 128'hB);
        chk("s1_count", count, 2);
        deq_ready = 1'b1;
        chk("s1_first_robid", deq_robid, 3);
        chk("s1_first_payload", deq_payload, 128'hA);
        step();
        chk("s1_second_robid", deq_robid, 4);
        step();
        chk("s1_empty", deq_valid, 0);
        deq_ready = 1'b0;

        // Fill with unready entries; one writeback wakes three of them.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            enq(7'(10 + i), (i == 2 || i == 4 || i == 6) ? 6'd20 : 6'(30 + i),
                6'd40, 1'b0, 1'b1, 128'(1000 + i));
        end
        chk("s2_full_count", count, 8);
        chk("s2_full_enq_ready", enq_ready, 0);
        wb_valid = 2'b10;
        wb_prd = {6'd20, 6'd0};
        #1;
        chk("s2_no_issue_in_wake_cycle", deq_valid, 0);
        step();
        wb_valid = '0;
        deq_ready = 1'b1;
        chk("s2_issue0", deq_robid, 12);
        step();
        chk("s2_issue1", deq_robid, 14);
        step();
        chk("s2_issue2", deq_robid, 16);
        step();
        chk("s2_drained", deq_valid, 0);
        chk("s2_count", count, 5);
        deq_ready = 1'b0;

        // Wrapped robids with a flush at 0x7F: only 0x00 goes away.
        do_reset();
        enq(7'h7E, 6'd1, 6'd1, 1'b1, 1'b1, 128'h7E);
        enq(7'h7F, 6'd1, 6'd1, 1'b1, 1'b1, 128'h7F);
        enq(7'h00, 6'd1, 6'd1, 1'b1, 1'b1, 128'h100);
        chk("s3_count_before", count, 3);
        flush_valid = 1'b1;
        flush_robid = 7'h7F;
        #1;
        chk("s3_flush_enq_ready", enq_ready, 0);
        chk("s3_flush_deq_valid", deq_valid, 0);
        step();
        flush_valid = 1'b0;
        chk("s3_count_after", count, 2);
        deq_ready = 1'b1;
        chk("s3_issue0", deq_robid, 7'h7E);
        step();
        chk("s3_issue1", deq_robid, 7'h7F);
        step();
        chk("s3_empty", deq_valid, 0);
        deq_ready = 1'b0;

        // Full queue: same-cycle enqueue is blocked, accepted the next cycle.
        do_reset();
        for (int i = 0; i < 8; i++) enq(7'(20 + i), 6'd1, 6'd1, 1'b1, 1'b1, 128'(2000 + i));
        chk("s4_count_full", count, 8);
        enq_valid = 1'b1; enq_robid = 7'd40; enq_prs1 = 6'd1; enq_prs2 = 6'd1;
        enq_src1_rdy = 1'b1; enq_src2_rdy = 1'b1; enq_payload = 128'd4000;
        deq_ready = 1'b1;
        #1;
        chk("s4_enq_blocked", enq_ready, 0);
        chk("s4_deq_oldest", deq_robid, 20);
        step();
        deq_ready = 1'b0;
        chk("s4_count_7", count, 7);
        chk("s4_enq_ready_again", enq_ready, 1);
        step();
        enq_valid = 1'b0;
        chk("s4_count_8", count, 8);
        deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("s4_drained_count", count, 0);
        deq_ready = 1'b0;

        // Writeback to prs1 in the enqueue cycle.
        do_reset();
        enq_valid = 1'b1; enq_robid = 7'd50; enq_prs1 = 6'd5; enq_prs2 = 6'd9;
        enq_src1_rdy = 1'b0; enq_src2_rdy = 1'b1; enq_payload = 128'h55;
        wb_valid = 2'b01;
        wb_prd = {6'd0, 6'd5};
        step();
        enq_valid = 1'b0;
        wb_valid = '0;
        deq_ready = 1'b1;
        chk("s5_bypass_issue", deq_valid, BYPASS);
        for (int i = 0; i < 4; i++) step();
        chk("s5_later_deq_valid", deq_valid, 0);
        chk("s5_count", count, BYPASS ? 0 : 1);
        deq_ready = 1'b0;

        // Reset asserted with four valid entries.
        do_reset();
        for (int i = 0; i < 4; i++) enq(7'(60 + i), 6'd2, 6'd3, 1'b1, 1'b1, 128'(3000 + i));
        chk("s6_deq_valid_before", deq_valid, 1);
        chk("s6_count_before", count, 4);
        reset_n = 1'b0;
        #1;
        chk("s6_deq_valid_in_reset", deq_valid, 0);
        chk("s6_count_in_reset", count, 0);
        chk("s6_enq_ready_in_reset", enq_ready, 0);
        step();

        // Randomized traffic checked by the model every cycle.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            enq_valid    = ($urandom_range(0, 9) < 6);
            enq_robid    = 7'($urandom);
            enq_prs1     = 6'($urandom_range(0, 7));
            enq_prs2     = 6'($urandom_range(0, 7));
            enq_src1_rdy = ($urandom_range(0, 2) == 0);
            enq_src2_rdy = ($urandom_range(0, 2) == 0);
            enq_payload  = {$urandom, $urandom, $urandom, $urandom};
            deq_ready    = ($urandom_range(0, 9) < 4);
            wb_valid     = 2'($urandom);
            wb_prd       = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
            flush_valid  = ($urandom_range(0, 29) == 0);
            flush_robid  = 7'($urandom);
            step();
        end
        idle_inputs();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
